// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_RW read/write registers followed by NUM_RO read-only status words.
// Define AXI_REGFILE_WR_PULSE_EN to add o_wr_pulse, a one-cycle per-register strobe on every OKAY write.

module axi_lite_regfile #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RW     = 16,
  parameter int unsigned NUM_RO     = 4
) (
  input  logic                                              i_axi_clk,
  input  logic                                              i_axi_rst,
  input  logic                                              i_awvalid,
  input  logic [ADDR_WIDTH-1:0]                             i_awaddr,
  output logic                                              o_awready,
  input  logic                                              i_wvalid,
  output logic                                              o_wready,
  input  logic [DATA_WIDTH-1:0]                             i_wdata,
  input  logic [DATA_WIDTH/8-1:0]                           i_wstrb,
  output logic                                              o_bvalid,
  input  logic                                              i_bready,
  output logic [1:0]                                        o_bresp,
  input  logic                                              i_arvalid,
  output logic                                              o_arready,
  input  logic [ADDR_WIDTH-1:0]                             i_araddr,
  output logic                                              o_rvalid,
  input  logic                                              i_rready,
  output logic [1:0]                                        o_rresp,
  output logic [DATA_WIDTH-1:0]                             o_rdata,
  output logic [NUM_RW*DATA_WIDTH-1:0]                      o_regs,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] i_status
`ifdef AXI_REGFILE_WR_PULSE_EN
  ,
  output logic [NUM_RW-1:0]                                 o_wr_pulse
`endif
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB  = $clog2(STRB_W);
  // Seven index bits cover the largest legal map (64 RW + 64 RO).
  localparam int unsigned IDX_MAX_W = 7;
  localparam int unsigned IDX_W     = ((ADDR_WIDTH - ADDR_LSB) < IDX_MAX_W) ?
                                      (ADDR_WIDTH - ADDR_LSB) : IDX_MAX_W;
  localparam int unsigned NUM_REGS  = NUM_RW + NUM_RO;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                  aw_full_q, aw_full_n;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_n;
  logic                  w_full_q, w_full_n;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_n;
  logic [STRB_W-1:0]     w_strb_q, w_strb_n;

  logic                  awready_n, wready_n, arready_n;
  logic                  bvalid_n, rvalid_n;
  logic [1:0]            bresp_n, rresp_n;
  logic [DATA_WIDTH-1:0] rdata_n;

  logic                  commit;
  logic                  reg_wr_en;
  logic [1:0]            wr_resp;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            rd_resp;

  logic                  unused_inputs;
  assign unused_inputs = ^{i_awaddr, i_araddr, i_status};

  // Write-side decode of the buffered AW index
  always_comb begin
    wr_resp = RESP_DECERR;
    if (32'(aw_idx_q) < NUM_RW) begin
      wr_resp = RESP_OKAY;
    end else if (32'(aw_idx_q) < NUM_REGS) begin
      wr_resp = RESP_SLVERR;
    end
  end

  assign commit    = aw_full_q & w_full_q & ~o_bvalid;
  assign reg_wr_en = commit & (wr_resp == RESP_OKAY);

  // Read-side decode and data mux straight from the live address
  always_comb begin
    ar_idx  = i_araddr[ADDR_LSB +: IDX_W];
    rd_word = '0;
    rd_resp = (32'(ar_idx) < NUM_REGS) ? RESP_OKAY : RESP_DECERR;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (32'(ar_idx) == k) rd_word = o_regs[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (32'(ar_idx) == NUM_RW + k) rd_word = i_status[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state for holders, handshake flags and response channels
  always_comb begin
    aw_full_n = aw_full_q;
    aw_idx_n  = aw_idx_q;
    w_full_n  = w_full_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    bvalid_n  = o_bvalid;
    bresp_n   = o_bresp;
    rvalid_n  = o_rvalid;
    rresp_n   = o_rresp;
    rdata_n   = o_rdata;

    if (commit) begin
      aw_full_n = 1'b0;
      w_full_n  = 1'b0;
      bvalid_n  = 1'b1;
      bresp_n   = wr_resp;
    end else if (o_bvalid && i_bready) begin
      bvalid_n = 1'b0;
    end

    if (i_awvalid && o_awready) begin
      aw_full_n = 1'b1;
      aw_idx_n  = i_awaddr[ADDR_LSB +: IDX_W];
    end

    if (i_wvalid && o_wready) begin
      w_full_n = 1'b1;
      w_data_n = i_wdata;
      w_strb_n = i_wstrb;
    end

    if (i_arvalid && o_arready) begin
      rvalid_n = 1'b1;
      rresp_n  = rd_resp;
      rdata_n  = rd_word;
    end else if (o_rvalid && i_rready) begin
      rvalid_n = 1'b0;
    end

    awready_n = ~aw_full_n;
    wready_n  = ~w_full_n;
    arready_n = ~rvalid_n;
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      o_awready <= 1'b0;
      o_wready  <= 1'b0;
      o_arready <= 1'b0;
      o_bvalid  <= 1'b0;
      o_bresp   <= '0;
      o_rvalid  <= 1'b0;
      o_rresp   <= '0;
      o_rdata   <= '0;
    end else begin
      aw_full_q <= aw_full_n;
      aw_idx_q  <= aw_idx_n;
      w_full_q  <= w_full_n;
      w_data_q  <= w_data_n;
      w_strb_q  <= w_strb_n;
      o_awready <= awready_n;
      o_wready  <= wready_n;
      o_arready <= arready_n;
      o_bvalid  <= bvalid_n;
      o_bresp   <= bresp_n;
      o_rvalid  <= rvalid_n;
      o_rresp   <= rresp_n;
      o_rdata   <= rdata_n;
    end
  end

  // Register array with per-byte strobes; o_regs is the flop output itself
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      o_regs <= '0;
    end else if (reg_wr_en) begin
      for (int unsigned k = 0; k < NUM_RW; k++) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (32'(aw_idx_q) == k && w_strb_q[b]) begin
            o_regs[k*DATA_WIDTH + b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

`ifdef AXI_REGFILE_WR_PULSE_EN
  logic [NUM_RW-1:0] wr_pulse_n;

  always_comb begin
    wr_pulse_n = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (reg_wr_en && 32'(aw_idx_q) == k) wr_pulse_n[k] = 1'b1;
    end
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      o_wr_pulse <= '0;
    end else begin
      o_wr_pulse <= wr_pulse_n;
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: directed scenarios plus randomized traffic against a register-map model.
// Builds with or without AXI_REGFILE_WR_PULSE_EN.

module tb_axi_lite_regfile;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned NRW  = 16;
  localparam int unsigned NRO  = 4;
  localparam int          TOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               awvalid, awready, wvalid, wready, bvalid, bready;
  logic               arvalid, arready, rvalid, rready;
  logic [AW-1:0]      awaddr, araddr;
  logic [DW-1:0]      wdata, rdata;
  logic [SW-1:0]      wstrb;
  logic [1:0]         bresp, rresp;
  logic [NRW*DW-1:0]  regs;
  logic [NRO*DW-1:0]  status;
`ifdef AXI_REGFILE_WR_PULSE_EN
  logic [NRW-1:0]     wr_pulse;
`endif

  axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_RO(NRO)
  ) dut (
    .i_axi_clk(clk),     .i_axi_rst(rst_n),
    .i_awvalid(awvalid), .i_awaddr(awaddr),   .o_awready(awready),
    .i_wvalid(wvalid),   .o_wready(wready),   .i_wdata(wdata),   .i_wstrb(wstrb),
    .o_bvalid(bvalid),   .i_bready(bready),   .o_bresp(bresp),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
    .o_rvalid(rvalid),   .i_rready(rready),   .o_rresp(rresp),   .o_rdata(rdata),
    .o_regs(regs),       .i_status(status)
`ifdef AXI_REGFILE_WR_PULSE_EN
    , .o_wr_pulse(wr_pulse)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] model [NRW];
  logic [1:0]    exp_b [$];
  logic [1:0]    exp_rresp [$];
  logic [DW-1:0] exp_rdata [$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 2) & 32'h7F);
  endfunction

  // Response monitor: pops the scoreboard on each B/R handshake and checks stability while stalled
  logic          b_seen = 1'b0, r_seen = 1'b0;
  logic [1:0]    b_hold, r_hold_resp;
  logic [DW-1:0] r_hold_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_seen = 1'b0;
      r_seen = 1'b0;
    end else begin
      if (bvalid) begin
        if (b_seen) check("bresp_stable", 64'(bresp), 64'(b_hold));
        b_seen = 1'b1;
        b_hold = bresp;
        if (bready) begin
          if (exp_b.size() == 0) check("b_unexpected", 64'(exp_b.size()), 64'd1);
          else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
          b_seen = 1'b0;
        end
      end
      if (rvalid) begin
        if (r_seen) begin
          check("rresp_stable", 64'(rresp), 64'(r_hold_resp));
          check("rdata_stable", 64'(rdata), 64'(r_hold_data));
        end
        r_seen      = 1'b1;
        r_hold_resp = rresp;
        r_hold_data = rdata;
        if (rready) begin
          if (exp_rresp.size() == 0) check("r_unexpected", 64'(exp_rresp.size()), 64'd1);
          else begin
            check("rresp", 64'(rresp), 64'(exp_rresp.pop_front()));
            check("rdata", 64'(rdata), 64'(exp_rdata.pop_front()));
          end
          r_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive_aw(input logic [31:0] addr, input int dly, output int hs_edge);
    hs_edge = -1;
    repeat (dly) begin @(posedge clk); #1; end
    awvalid = 1'b1;
    awaddr  = addr;
    for (int n = 0; n < TOUT; n++) begin
      @(negedge clk);
      if (awready) begin hs_edge = cyc + 1; break; end
    end
    check("aw_handshake", 64'(hs_edge >= 0), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("awready_after_aw", 64'(awready), 64'd0);
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output int hs_edge);
    hs_edge = -1;
    repeat (dly) begin @(posedge clk); #1; end
    wvalid = 1'b1;
    wdata  = data;
    wstrb  = strb;
    for (int n = 0; n < TOUT; n++) begin
      @(negedge clk);
      if (wready) begin hs_edge = cyc + 1; break; end
    end
    check("w_handshake", 64'(hs_edge >= 0), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check("wready_after_w", 64'(wready), 64'd0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int idx, aw_e, w_e, last, seen;
    logic [1:0] resp;
    logic [NRW-1:0] exp_pulse;
    idx = idx_of(addr);
    if (idx < int'(NRW))            resp = 2'b00;
    else if (idx < int'(NRW + NRO)) resp = 2'b10;
    else                            resp = 2'b11;
    exp_pulse = '0;
    if (resp == 2'b00) exp_pulse[idx] = 1'b1;
    exp_b.push_back(resp);
    fork
      drive_aw(addr, aw_dly, aw_e);
      drive_w(data, strb, w_dly, w_e);
    join
    if (resp == 2'b00) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    last = (aw_e > w_e) ? aw_e : w_e;
    seen = -1;
    for (int n = 0; n < TOUT; n++) begin
      if (bvalid) begin seen = cyc; break; end
      @(negedge clk);
    end
    check("b_latency", 64'(seen), 64'(last + 1));
    check("awready_while_b", 64'(awready), 64'd1);
    check("wready_while_b", 64'(wready), 64'd1);
`ifdef AXI_REGFILE_WR_PULSE_EN
    check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
`endif
    @(negedge clk);
    check("bvalid_held", 64'(bvalid), 64'd1);
`ifdef AXI_REGFILE_WR_PULSE_EN
    check("wr_pulse_one_cycle", 64'(wr_pulse), 64'd0);
`endif
    repeat (b_dly) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int idx, hs;
    idx = idx_of(addr);
    if (idx < int'(NRW)) begin
      exp_rresp.push_back(2'b00);
      exp_rdata.push_back(model[idx]);
    end else if (idx < int'(NRW + NRO)) begin
      exp_rresp.push_back(2'b00);
      exp_rdata.push_back(status[(idx - int'(NRW))*DW +: DW]);
    end else begin
      exp_rresp.push_back(2'b11);
      exp_rdata.push_back('0);
    end
    repeat (ar_dly) begin @(posedge clk); #1; end
    arvalid = 1'b1;
    araddr  = addr;
    hs = -1;
    for (int n = 0; n < TOUT; n++) begin
      @(negedge clk);
      if (arready) begin
        check("rvalid_before_ar", 64'(rvalid), 64'd0);
        hs = cyc + 1;
        break;
      end
    end
    check("ar_handshake", 64'(hs >= 0), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("r_latency", 64'(rvalid), 64'd1);
    check("arready_while_r", 64'(arready), 64'd0);
    repeat (r_dly) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
    check("arready_after_r", 64'(arready), 64'd1);
    check("rvalid_cleared", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_regs();
    for (int k = 0; k < int'(NRW); k++) check("regs_word", 64'(regs[k*DW +: DW]), 64'(model[k]));
  endtask

  // Asserts reset, checks outputs clear asynchronously, then releases and checks readies rise
  task automatic do_reset();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_regs",    64'(|regs),   64'd0);
    exp_b.delete(); exp_rresp.delete(); exp_rdata.delete();
    foreach (model[i]) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_wready",  64'(wready),  64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int op, r, idx;
    logic [31:0] addr;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; status = '0;
    #2;
    do_reset();

    // Basic write then read of word 2
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("req_w2_value", 64'(regs[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    axi_read(32'h08, 0, 0);

    // W arrives three cycles ahead of AW
    axi_write(32'h04, 32'h0BADCAFE, 4'hF, 3, 0, 0);
    check("req_w1_late_aw", 64'(regs[1*DW +: DW]), 64'h0000_0000_0BAD_CAFE);

    // Byte strobes
    axi_write(32'h04, 32'h11223344, 4'hF, 0, 1, 1);
    axi_write(32'h04, 32'hAABBCCDD, 4'h5, 1, 0, 0);
    check("req_strb_merge", 64'(regs[1*DW +: DW]), 64'h0000_0000_11BB_33DD);
    axi_write(32'h08, 32'h12345678, 4'h0, 0, 0, 0);
    check("req_strb_zero", 64'(regs[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);

    // Read-only and unmapped space
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    check_regs();
    status[31:0] = 32'h5A5A0001;
    axi_read(32'h40, 0, 1);
    axi_read(32'h100, 0, 0);
    axi_write(32'h100, 32'h5555AAAA, 4'hF, 2, 0, 0);
    check_regs();

    // Long B stall
    axi_write(32'h0C, 32'hC0FFEE00, 4'hF, 0, 0, 5);

    // Read and write of the same register on one edge returns the old value
    axi_write(32'h14, 32'h01020304, 4'hF, 0, 0, 0);
    fork
      axi_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 1);
      axi_read(32'h14, 1, 0);
    join
    check("same_edge_new_value", 64'(regs[5*DW +: DW]), 64'h0000_0000_CAFE_F00D);

    // Reset with AW and W both captured but not yet committed
    @(posedge clk); #1;
    awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    #2;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("no_stale_b", 64'(bvalid), 64'd0);
    end
    @(posedge clk); #1;
    check_regs();
    axi_read(32'h08, 0, 0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 7)      idx = int'($urandom_range(0, NRW - 1));
      else if (r < 9) idx = int'($urandom_range(NRW, NRW + NRO - 1));
      else            idx = int'($urandom_range(NRW + NRO, 127));
      addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if (op == 1) begin
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        for (int s = 0; s < int'(NRO); s++) status[s*DW +: DW] = $urandom;
        axi_read(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      if (it % 10 == 9) check_regs();
    end

    repeat (4) @(posedge clk);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);
    check("r_queue_drained", 64'(exp_rresp.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: width of i_awaddr and i_araddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, legal 32 or 64: width of data buses; wstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_RW, default 16, range 1..64: number of read/write registers, at indices 0..NUM_RW-1.
REQ-004 SHALL have parameter NUM_RO, default 4, range 0..64: number of read-only status registers, at indices NUM_RW..NUM_RW+NUM_RO-1.
REQ-005 SHALL have ports, clock and reset first: i_axi_clk in 1 clock; i_axi_rst in 1 reset, asynchronous, active-low.
REQ-006 SHALL have write ports: i_awvalid in 1; i_awaddr in ADDR_WIDTH; o_awready out 1; i_wvalid in 1; o_wready out 1; i_wdata in DATA_WIDTH; i_wstrb in DATA_WIDTH/8; o_bvalid out 1; i_bready in 1; o_bresp out 2.
REQ-007 SHALL have read ports: i_arvalid in 1; o_arready out 1; i_araddr in ADDR_WIDTH; o_rvalid out 1; i_rready in 1; o_rresp out 2; o_rdata out DATA_WIDTH.
REQ-008 SHALL have o_regs out NUM_RW*DATA_WIDTH (register k at bits k*DATA_WIDTH upward) and i_status in max(NUM_RO,1)*DATA_WIDTH (ignored when NUM_RO=0).

Function
REQ-009 SHALL decode register index as address bits above ADDR_LSB = log2(DATA_WIDTH/8); low ADDR_LSB bits and bits above the index field SHALL be ignored.
REQ-010 SHALL accept AW and W independently: each has a one-deep holding register; o_awready / o_wready high when its holder is empty.
REQ-011 SHALL commit a write on the cycle both holders are full and no B response is pending; holders empty and o_bvalid asserts on the next edge (minimum 2 cycles, AW+W handshake to bvalid).
REQ-012 SHALL apply i_wstrb per byte; bytes with strobe 0 keep their value; a strobe of all zeros SHALL still return OKAY.
REQ-013 SHALL return bresp OKAY (00) for RW indices, SLVERR (10) for RO indices (no state change), DECERR (11) for index >= NUM_RW+NUM_RO (no state change).
REQ-014 SHALL hold o_bvalid and o_bresp stable until i_bready; at most one B outstanding; holders may refill while B pending.
REQ-015 SHALL assert o_arready when no R response is pending; on AR handshake, o_rvalid and o_rdata SHALL be registered on the next edge (1-cycle latency).
REQ-016 SHALL return rresp OKAY with register or i_status value (sampled at AR handshake edge) for valid indices, DECERR with rdata 0 otherwise.
REQ-017 SHALL hold o_rvalid, o_rdata and o_rresp stable until i_rready; o_arready SHALL go high in the cycle after the R handshake.
REQ-018 SHALL, when a read and a write to the same register occur on the same edge, return the pre-write value.
REQ-019 SHALL drive o_regs directly from the register flops, with no extra latency.

Reset
REQ-020 SHALL, while i_axi_rst is low, asynchronously clear all registers, holders and pending flags: o_awready=0, o_wready=0, o_arready=0, o_bvalid=0, o_rvalid=0, o_bresp=0, o_rresp=0, o_rdata=0, o_regs=0.
REQ-021 SHALL raise o_awready, o_wready and o_arready in the first cycle after reset deassertion; transactions in flight at reset SHALL be discarded.

Configuration
REQ-022 SHALL, with macro AXI_REGFILE_WR_PULSE_EN defined, add output o_wr_pulse (NUM_RW bits) that pulses bit k high for exactly one cycle on the edge an OKAY write commits to register k.
REQ-023 SHALL, without AXI_REGFILE_WR_PULSE_EN, omit o_wr_pulse from the port list, with all other behaviour unchanged.

Verification
REQ-024 Bench SHALL cover: write 0xDEADBEEF to addr 0x08, strb 0xF -> bresp 00, o_regs word 2 = 0xDEADBEEF; read 0x08 -> rdata 0xDEADBEEF, rresp 00, rvalid one cycle after AR handshake.
REQ-025 Bench SHALL cover: W presented 3 cycles before AW to addr 0x04 -> wready drops after W handshake, bvalid 2 cycles after AW handshake, bresp 00.
REQ-026 Bench SHALL cover: reg 1 = 0x11223344, then write 0xAABBCCDD with strb 0x5 -> reg 1 = 0x11BB33DD.
REQ-027 Bench SHALL cover: write to RO index 16 (addr 0x40) -> bresp 10, no change; read addr 0x40 with i_status word 0 = 0x5A5A0001 -> rdata 0x5A5A0001; read addr 0x100 -> rresp 11, rdata 0.
REQ-028 Bench SHALL cover: bready held low 5 cycles -> bvalid/bresp stable, awready returns high while B pending; reset asserted mid-transaction -> all outputs 0 immediately, registers 0.
REQ-029 Bench SHALL cover, with AXI_REGFILE_WR_PULSE_EN: write reg 3 -> o_wr_pulse = 0x0008 for exactly one cycle; SLVERR write -> no pulse.
